// File: rtl/mine_placer.sv
// mine_placer: builds an 8x8 Buscaminas board. On start it clears the board, places
// pseudo-random distinct bombs with a 16-bit LFSR, then scans every cell once to write
// its adjacent-bomb count. The finished board is held on board_out until the next run.
// Optional feature macro: MINE_PLACER_SAFE_CELL_EN adds a cell that never receives a bomb.
module mine_placer #(
    parameter int unsigned MAX_BOMBS    = 63,
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bombs,
    input  logic [15:0] seed,
`ifdef MINE_PLACER_SAFE_CELL_EN
    input  logic [2:0]  safe_row,
    input  logic [2:0]  safe_col,
`endif
    output logic        busy,
    output logic        done,
    output logic [6:0]  placed_count,
    output logic [8:0]  board_out [0:7][0:7]
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StClear = 3'd1;
    localparam logic [2:0] StPlace = 3'd2;
    localparam logic [2:0] StCount = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    logic [2:0]  state_q;
    logic [15:0] lfsr_q;
    logic [6:0]  target_q;
    logic [6:0]  placed_q;
    logic [5:0]  scan_q;
    logic [63:0] bomb_q;
    logic [3:0]  cnt_q [0:63];

    logic [15:0] lfsr_step;
    logic [5:0]  cand;
    logic        cand_ok;
    logic [6:0]  target_clamp;
    logic [3:0]  nb_cnt;
    int          nr;
    int          nc;

`ifdef MINE_PLACER_SAFE_CELL_EN
    logic [5:0] safe_q;
`endif

    // Next LFSR value and the candidate cell it selects
    always_comb begin
        lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        cand      = lfsr_step[5:0];
`ifdef MINE_PLACER_SAFE_CELL_EN
        cand_ok   = ~bomb_q[cand] && (cand != safe_q);
`else
        cand_ok   = ~bomb_q[cand];
`endif
    end

    // Clamp the requested bomb count; the safe cell build must leave one cell free
    always_comb begin
        if (32'(bombs) > MAX_BOMBS) begin
            target_clamp = 7'(MAX_BOMBS);
        end else begin
            target_clamp = bombs[6:0];
        end
`ifdef MINE_PLACER_SAFE_CELL_EN
        if (target_clamp > 7'd63) begin
            target_clamp = 7'd63;
        end
`endif
    end

    // Bomb count among the in-bounds neighbours of the scanned cell (no wrap-around)
    always_comb begin
        nb_cnt = 4'd0;
        nr     = 0;
        nc     = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                nr = int'(scan_q[5:3]) + dr;
                nc = int'(scan_q[2:0]) + dc;
                if ((dr != 0 || dc != 0) && nr >= 0 && nr <= 7 && nc >= 0 && nc <= 7) begin
                    nb_cnt = nb_cnt + {3'b000, bomb_q[6'(nr * 8 + nc)]};
                end
            end
        end
    end

    // Control FSM: sequencing, LFSR, bomb tally and scan index
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            lfsr_q   <= DEFAULT_SEED;
            target_q <= 7'd0;
            placed_q <= 7'd0;
            scan_q   <= 6'd0;
`ifdef MINE_PLACER_SAFE_CELL_EN
            safe_q   <= 6'd0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        target_q <= target_clamp;
                        lfsr_q   <= (seed == 16'h0000) ? DEFAULT_SEED : seed;
`ifdef MINE_PLACER_SAFE_CELL_EN
                        safe_q   <= {safe_row, safe_col};
`endif
                        state_q  <= StClear;
                    end
                end
                StClear: begin
                    placed_q <= 7'd0;
                    scan_q   <= 6'd0;
                    state_q  <= (target_q == 7'd0) ? StCount : StPlace;
                end
                StPlace: begin
                    lfsr_q <= lfsr_step;
                    if (cand_ok) begin
                        placed_q <= placed_q + 7'd1;
                        if (placed_q + 7'd1 == target_q) begin
                            state_q <= StCount;
                        end
                    end
                end
                StCount: begin
                    scan_q <= scan_q + 6'd1;
                    if (scan_q == 6'd63) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Board storage: cleared in CLEAR, bombs set in PLACE, counts written in COUNT
    always_ff @(posedge clk) begin
        if (rst) begin
            bomb_q <= 64'd0;
            for (int i = 0; i < 64; i++) begin
                cnt_q[i] <= 4'd0;
            end
        end else begin
            case (state_q)
                StClear: begin
                    bomb_q <= 64'd0;
                    for (int i = 0; i < 64; i++) begin
                        cnt_q[i] <= 4'd0;
                    end
                end
                StPlace: begin
                    if (cand_ok) begin
                        bomb_q[cand] <= 1'b1;
                    end
                end
                StCount: begin
                    cnt_q[scan_q] <= nb_cnt;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign placed_count = placed_q;

    for (genvar gr = 0; gr < 8; gr++) begin : g_row
        for (genvar gc = 0; gc < 8; gc++) begin : g_col
            assign board_out[gr][gc] = {4'b0000, cnt_q[gr * 8 + gc], bomb_q[gr * 8 + gc]};
        end
    end

endmodule
